// File: rtl/rr_interconnect.sv
// rr_interconnect: N-master to 1-slave req/ack interconnect, round-robin grant.
// Optional slave-response timeout is built when ARB_TIMEOUT_EN is defined.
module rr_interconnect #(
  parameter int N_MASTERS      = 4,
  parameter int SEL_W          = $clog2(N_MASTERS),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [N_MASTERS-1:0] M_req,
  output logic [N_MASTERS-1:0] M_ack,
  output logic [N_MASTERS-1:0] M_err,
  output logic                 S_req,
  input  logic                 S_ack,
  output logic [SEL_W-1:0]     Select,
  output logic                 Busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [SEL_W-1:0] TOP = SEL_W'(N_MASTERS - 1);

  logic [0:0]       state;
  logic [SEL_W-1:0] g;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] w;
  logic [SEL_W-1:0] idx;
  logic             found;
  logic             req_g;
  logic             tmo;
  logic             done;

  // Rotating search from last+1, wrapping at N_MASTERS-1.
  always_comb begin
    found = 1'b0;
    w     = '0;
    idx   = last;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = (idx == TOP) ? '0 : idx + SEL_W'(1);
      if (!found && M_req[idx]) begin
        found = 1'b1;
        w     = idx;
      end
    end
  end

  assign Busy  = (state == GRANT);
  assign req_g = M_req[g];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  assign tmo = Busy & req_g & ~S_ack &
               (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count unanswered grant cycles; cleared while idle so it restarts per grant.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (!Busy) begin
      cnt <= '0;
    end else if (!S_ack) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign tmo = 1'b0;
`endif

  assign S_req  = Busy & req_g & ~tmo;
  assign done   = ~req_g | S_ack | tmo;
  assign Select = Busy ? g : '0;

  // Ack and error are routed only to the granted master.
  always_comb begin
    M_ack    = '0;
    M_err    = '0;
    M_ack[g] = Busy & req_g & S_ack;
    M_err[g] = tmo;
  end

  // Arbitration FSM; a withdrawn master keeps last, so it loses its turn.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      g     <= '0;
      last  <= TOP;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            g     <= w;
            last  <= w;
          end
        end
        GRANT: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_interconnect.sv
// tb_rr_interconnect: directed and randomized checks of rr_interconnect.
// Random phase is scored against a round-robin reference model.
module tb_rr_interconnect;

  localparam int N = 4;
  localparam int T = 8;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic [3:0] M_req = '0;
  logic       S_ack = 1'b0;
  logic [3:0] M_ack;
  logic [3:0] M_err;
  logic       S_req;
  logic [1:0] Select;
  logic       Busy;

  logic [2:0] M_req3 = '0;
  logic       S_ack3 = 1'b0;
  logic [2:0] M_ack3;
  logic [2:0] M_err3;
  logic       S_req3;
  logic [1:0] Select3;
  logic       Busy3;

  rr_interconnect #(
    .N_MASTERS(N),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK(CLK), .RSTn(RSTn),
    .M_req(M_req), .M_ack(M_ack), .M_err(M_err),
    .S_req(S_req), .S_ack(S_ack),
    .Select(Select), .Busy(Busy)
  );

  rr_interconnect #(
    .N_MASTERS(3),
    .TIMEOUT_CYCLES(T)
  ) dut3 (
    .CLK(CLK), .RSTn(RSTn),
    .M_req(M_req3), .M_ack(M_ack3), .M_err(M_err3),
    .S_req(S_req3), .S_ack(S_ack3),
    .Select(Select3), .Busy(Busy3)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  bit m_busy;
  int m_g;
  int m_last;
  int m_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RSTn   = 1'b0;
    M_req  = '0;
    S_ack  = 1'b0;
    M_req3 = '0;
    S_ack3 = 1'b0;
    tick();
    RSTn   = 1'b1;
    m_busy = 1'b0;
    m_g    = 0;
    m_last = N - 1;
    m_cnt  = 0;
  endtask

  function automatic int rr_pick(input int lst, input logic [3:0] r);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (lst + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sreq"}, 32'(S_req), 0);
    chk({tag, "_ack"}, 32'(M_ack), 0);
    chk({tag, "_err"}, 32'(M_err), 0);
    chk({tag, "_sel"}, 32'(Select), 0);
    chk({tag, "_busy"}, 32'(Busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int b;
    int seq3;
    int acked;
    logic [3:0] r;
    bit e_ack;
    bit e_tmo;
    bit e_sreq;

    // reset state
    #2;
    chk_all_zero("rst");
    do_reset();

    // async reset in the middle of a grant
    M_req = 4'b0010;
    @(negedge CLK);
    chk("mid_idle_busy", 32'(Busy), 0);
    tick();
    @(negedge CLK);
    chk("mid_busy", 32'(Busy), 1);
    chk("mid_sel", 32'(Select), 1);
    chk("mid_sreq", 32'(S_req), 1);
    #2;
    RSTn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    RSTn  = 1'b1;
    M_req = 4'b1111;
    @(negedge CLK);
    chk("post_rst_busy", 32'(Busy), 1);
    chk("post_rst_sel", 32'(Select), 0);

    // fairness: all requesting, ack one cycle after S_req
    do_reset();
    M_req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      b = 0;
      @(negedge CLK);
      while (!Busy && b < 5) begin
        @(negedge CLK);
        b++;
      end
      chk("fair_busy", 32'(Busy), 1);
      chk("fair_sel", 32'(Select), 32'(k % 4));
      chk("fair_noack", 32'(M_ack), 0);
      tick();
      S_ack = 1'b1;
      @(negedge CLK);
      chk("fair_ack", 32'(M_ack), 32'(1 << (k % 4)));
      chk("fair_sreq", 32'(S_req), 1);
      tick();
      S_ack = 1'b0;
    end

    // single master with slave ack tied high
    do_reset();
    M_req = 4'b0100;
    S_ack = 1'b1;
    @(negedge CLK);
    chk("one_t_busy", 32'(Busy), 0);
    chk("one_t_ack", 32'(M_ack), 0);
    tick();
    @(negedge CLK);
    chk("one_t1_sreq", 32'(S_req), 1);
    chk("one_t1_sel", 32'(Select), 2);
    chk("one_t1_ack", 32'(M_ack), 32'(4'b0100));
    tick();
    @(negedge CLK);
    chk("one_t2_busy", 32'(Busy), 0);
    M_req = '0;
    S_ack = 1'b0;

    // withdrawal before ack loses the turn
    do_reset();
    M_req = 4'b0010;
    tick();
    @(negedge CLK);
    chk("wd_busy", 32'(Busy), 1);
    chk("wd_sel", 32'(Select), 1);
    tick();
    M_req = 4'b0000;
    S_ack = 1'b1;
    #1;
    chk("wd_sreq", 32'(S_req), 0);
    chk("wd_ack", 32'(M_ack), 0);
    tick();
    M_req = 4'b1010;
    S_ack = 1'b0;
    @(negedge CLK);
    chk("wd_idle", 32'(Busy), 0);
    tick();
    @(negedge CLK);
    chk("wd_next_sel", 32'(Select), 3);
    chk("wd_next_busy", 32'(Busy), 1);

    // three masters, all requesting, slave always acking
    do_reset();
    M_req3 = 3'b111;
    S_ack3 = 1'b1;
    seq3 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      chk("n3_range", 32'(Select3 < 2'd3), 1);
      if (Busy3) begin
        chk("n3_sel", 32'(Select3), 32'(seq3 % 3));
        seq3++;
      end
    end
    chk("n3_grants", 32'(seq3), 4);
    M_req3 = '0;
    S_ack3 = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // timeout with silent slave, then ack in the final cycle
    do_reset();
    M_req = 4'b0001;
    @(negedge CLK);
    for (int c = 1; c <= T; c++) begin
      tick();
      @(negedge CLK);
      chk("to_busy", 32'(Busy), 1);
      chk("to_err", 32'(M_err), (c == T) ? 32'(1) : 32'(0));
      chk("to_sreq", 32'(S_req), (c == T) ? 32'(0) : 32'(1));
    end
    tick();
    @(negedge CLK);
    chk("to_idle", 32'(Busy), 0);
    for (int c = 1; c <= T; c++) begin
      tick();
      if (c == T) S_ack = 1'b1;
      @(negedge CLK);
      if (c == T) begin
        chk("to_ack_win", 32'(M_ack), 1);
        chk("to_ack_noerr", 32'(M_err), 0);
      end
    end
    tick();
    M_req = '0;
    S_ack = 1'b0;
`endif

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK);
      r     = M_req;
      e_tmo = 1'b0;
`ifdef ARB_TIMEOUT_EN
      e_tmo = m_busy && r[m_g] && !S_ack && (m_cnt == T - 1);
`endif
      e_ack  = m_busy && r[m_g] && S_ack;
      e_sreq = m_busy && r[m_g] && !e_tmo;
      chk("rnd_busy", 32'(Busy), 32'(m_busy));
      chk("rnd_sel", 32'(Select), m_busy ? 32'(m_g) : 32'(0));
      chk("rnd_sreq", 32'(S_req), 32'(e_sreq));
      chk("rnd_ack", 32'(M_ack), e_ack ? 32'(1 << m_g) : 32'(0));
      chk("rnd_err", 32'(M_err), e_tmo ? 32'(1 << m_g) : 32'(0));
      acked = e_ack ? m_g : -1;
      if (!m_busy) begin
        b = rr_pick(m_last, r);
        if (b >= 0) begin
          m_busy = 1'b1;
          m_g    = b;
          m_last = b;
          m_cnt  = 0;
        end
      end else if (!r[m_g] || e_ack || e_tmo) begin
        m_busy = 1'b0;
      end else if (!S_ack) begin
        m_cnt++;
      end
      tick();
      if (acked >= 0) r[acked] = 1'b0;
      if (m_busy && $urandom_range(15) == 0) r[m_g] = 1'b0;
      for (int i = 0; i < N; i++)
        if (!r[i] && $urandom_range(99) < 30) r[i] = 1'b1;
      M_req = r;
      S_ack = ($urandom_range(99) < ((c < 300) ? 35 : 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_interconnect.md
# rr_interconnect

- Parametrised N-master to 1-slave request/acknowledge interconnect with round-robin arbitration.
- Generalises the two-master adder/multiplier arbiter of the FPU to `N_MASTERS` requesters, for example adder, multiplier, divider and sqrt units sharing one result/bus slave.
- Drives the slave request and a binary `Select` for the downstream datapath mux, and routes the slave acknowledge back to the granted master only.
- Sits between the FPU arithmetic units and the shared slave.

## Interface

Parameters:
- `N_MASTERS`, default 4: number of requesting masters; legal range 2..16.
- `SEL_W`, default `$clog2(N_MASTERS)`: width of `Select`; derived, not overridden.
- `TIMEOUT_CYCLES`, default 64: slave-response limit in cycles; only used with `ARB_TIMEOUT_EN`; legal range ≥2.

Ports:
- `CLK` input 1: the single clock; all state changes on its rising edge.
- `RSTn` input 1: reset, asynchronous and active-low.
- `M_req` input N_MASTERS: per-master request, level; held until acked or withdrawn.
- `M_ack` output N_MASTERS: per-master acknowledge, one-cycle pulse, at most one bit set.
- `M_err` output N_MASTERS: per-master timeout pulse; constant 0 without `ARB_TIMEOUT_EN`.
- `S_req` output 1: request to the slave.
- `S_ack` input 1: slave acknowledge.
- `Select` output SEL_W: index of the granted master; drives the datapath mux.
- `Busy` output 1: high while a grant is held.

## Operation

- Two-state FSM:
  - `IDLE`: arbitrates.
  - `GRANT`: holds a grant to master `g`.
- Registered state: FSM state, `g` (SEL_W), round-robin pointer `last` (SEL_W), timeout counter.
- **IDLE:**
  - Search `M_req` starting at index `(last+1) mod N_MASTERS` upward, wrapping.
  - The first set bit is the winner `w`.
  - If a winner exists: next state `GRANT`, `g<=w`, `last<=w`.
  - If `M_req==0`: stay in `IDLE`, no register changes.
- **GRANT:**
  - `S_req = M_req[g]`, combinational.
  - `M_ack[g] = S_ack & M_req[g]`; all other `M_ack` bits are 0.
  - If `S_ack & M_req[g]`: next state `IDLE`.
  - If `M_req[g]==0` (withdrawal): `S_req=0`, no ack, next state `IDLE`; `last` keeps `g`, so the withdrawn master loses its turn.
  - `S_ack` seen in `IDLE` is ignored and produces no `M_ack`.
- **Outputs by state:**
  - `Select = g` while in `GRANT`, 0 in `IDLE`.
  - `Busy = (state==GRANT)`.
  - `M_err` pulses only on timeout (see Configuration).
- **Reset** (asynchronous, any cycle including mid-grant):
  - state=`IDLE`, `g=0`, `last=N_MASTERS-1` (master 0 wins the first arbitration), counter=0.
  - Outputs: `S_req=0`, `M_ack=0`, `M_err=0`, `Select=0`, `Busy=0`.
  - An interrupted transaction is dropped silently.
- **Fairness:** with all masters requesting continuously, grants cycle 0,1,…,N-1,0… Any requester is granted within N_MASTERS transactions.
- **Non-power-of-two N_MASTERS:** `Select` values ≥ N_MASTERS never occur, and the search wraps at N_MASTERS−1.

## Timing

- `M_req[i]` rising in cycle t, sampled in `IDLE` at edge t→t+1: `S_req`, `Select=i` and `Busy` are high from cycle t+1.
- `S_ack` in cycle k while in `GRANT`: `M_ack[g]` is high in the same cycle k (combinational pass-through), and state returns to `IDLE` at edge k+1.
- Minimum spacing between transactions: one `IDLE` arbitration cycle; a continuously serviced stream uses 2 cycles per transaction when the slave acks immediately.
- `S_req` may drop in the cycle `M_req[g]` drops, since it is combinational from the input.
- No combinational path from `M_req` to `Select`; `Select` is registered via `g` and the state.

## Configuration

- Macro: `ARB_TIMEOUT_EN`.
- **Defined:**
  - The counter clears on entry to `GRANT` and increments each `GRANT` cycle without `S_ack`.
  - In the cycle where the count equals `TIMEOUT_CYCLES-1` and `S_ack==0`: `M_err[g]=1` for that cycle, `S_req=0`, next state `IDLE`.
  - A slave ack arriving in that same cycle wins: ack, no error.
- **Undefined:** no counter is built, `M_err` is tied to 0, and `GRANT` waits for `S_ack` or withdrawal indefinitely.

## Test plan

- Reset mid-grant (`M_req=4'b0010`, in `GRANT`) → all outputs 0 asynchronously. After release, `M_req=4'b1111` gives first grant `Select=0`.
- All four masters requesting, slave acks 1 cycle after `S_req` → grant order 0,1,2,3,0,1; one `M_ack` pulse per grant; no `M_ack` to non-granted masters.
- `M_req=4'b0100` only, `S_ack` tied high → `S_req` and `Select=2` in cycle t+1, `M_ack[2]` in cycle t+1, `Busy` low in t+2.
- Master 1 granted, drops `M_req[1]` before ack → `S_req` falls the same cycle, no `M_ack`, state returns to `IDLE`. With masters 1 and 3 then requesting, next grant is 3.
- `N_MASTERS=3`, all requesting continuously → `Select` sequence 0,1,2,0; `Select` never equals 3.
- `ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=8`, `S_ack` held 0 → `M_err[g]` pulses in the 8th `GRANT` cycle, then `IDLE`. Repeat with `S_ack` in that cycle → `M_ack`, no `M_err`.
